// File: rtl/chess_clock_timer.sv
// Two-player chess clock with a one-second prescaler and Fischer increment.
//
// Parameters:
//   CLOCK_FREQ  clock cycles per one-second tick (>= 2)
//   MINUTES     initial minutes per player (0..99)
//   SECONDS     initial seconds per player (0..59)
//   INCREMENT   seconds added to the mover's time on turn end (0..59)
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   start        level request to begin/resume counting
//   pause        level request to halt counting (beats start)
//   turn_end     one-cycle pulse ending the active player's move
//   active       side to move: 0 = white, 1 = black
//   running      high while counting
//   timeout      bit0 = white flag fallen, bit1 = black flag fallen
//   w_*/b_*      per-player minutes (binary) and seconds tens/units (BCD)
module chess_clock_timer #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned MINUTES    = 5,
  parameter int unsigned SECONDS    = 0,
  parameter int unsigned INCREMENT  = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       turn_end,
  output logic       active,
  output logic       running,
  output logic [1:0] timeout,
  output logic [6:0] w_min,
  output logic [2:0] w_sec_tens,
  output logic [3:0] w_sec_units,
  output logic [6:0] b_min,
  output logic [2:0] b_sec_tens,
  output logic [3:0] b_sec_units
);

  localparam int unsigned PW = $clog2(CLOCK_FREQ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_FREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, TIMEOUT} state_e;

  typedef struct packed {
    logic [6:0] m;
    logic [2:0] t;
    logic [3:0] u;
  } tm_t;

  localparam tm_t INIT = '{m: 7'(MINUTES), t: 3'(SECONDS / 10), u: 4'(SECONDS % 10)};

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          active_q, active_d;
  logic          running_q, running_d;
  logic [1:0]    timeout_q, timeout_d;
  tm_t           w_q, w_d, b_q, b_d;

  tm_t  cur, dec, inc;
  logic tick;

  // One-second BCD decrement; caller guarantees the time is non-zero.
  function automatic tm_t dec1(input tm_t x);
    tm_t r;
    r = x;
    if (x.u != 4'd0) begin
      r.u = x.u - 4'd1;
    end else begin
      r.u = 4'd9;
      if (x.t != 3'd0) begin
        r.t = x.t - 3'd1;
      end else begin
        r.t = 3'd5;
        r.m = x.m - 7'd1;
      end
    end
    return r;
  endfunction

  // Add the increment with carry into minutes, saturating at 99:59.
  function automatic tm_t add_inc(input tm_t x);
    tm_t        r;
    logic [6:0] s;
    logic [7:0] m;
    s = 7'(x.t) * 7'd10 + 7'(x.u) + 7'(INCREMENT);
    m = {1'b0, x.m};
    if (s >= 7'd60) begin
      s = s - 7'd60;
      m = m + 8'd1;
    end
    if (m > 8'd99) begin
      r = '{m: 7'd99, t: 3'd5, u: 4'd9};
    end else begin
      r.m = m[6:0];
      r.t = 3'(s / 7'd10);
      r.u = 4'(s % 7'd10);
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    active_d  = active_q;
    timeout_d = timeout_q;
    w_d       = w_q;
    b_d       = b_q;

    cur  = active_q ? b_q : w_q;
    dec  = dec1(cur);
    inc  = add_inc(cur);
    tick = (presc_q == PRESC_MAX);

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (start) begin
          state_d  = RUN;
          active_d = 1'b0;
        end
      end
      RUN: begin
        if (turn_end) begin
          // Turn end wins over a coincident tick: the tick is dropped.
          presc_d  = '0;
          active_d = ~active_q;
          if (active_q) b_d = inc;
          else          w_d = inc;
        end else if (tick) begin
          presc_d = '0;
          if (active_q) b_d = dec;
          else          w_d = dec;
          if (dec == '0) begin
            timeout_d[active_q] = 1'b1;
            state_d             = TIMEOUT;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (pause && state_d == RUN) state_d = PAUSED;
      end
      PAUSED: begin
        if (start && !pause) state_d = RUN;
      end
      TIMEOUT: begin
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      active_q  <= 1'b0;
      running_q <= 1'b0;
      timeout_q <= '0;
      w_q       <= INIT;
      b_q       <= INIT;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      active_q  <= active_d;
      running_q <= running_d;
      timeout_q <= timeout_d;
      w_q       <= w_d;
      b_q       <= b_d;
    end
  end

  assign active      = active_q;
  assign running     = running_q;
  assign timeout     = timeout_q;
  assign w_min       = w_q.m;
  assign w_sec_tens  = w_q.t;
  assign w_sec_units = w_q.u;
  assign b_min       = b_q.m;
  assign b_sec_tens  = b_q.t;
  assign b_sec_units = b_q.u;

endmodule

// File: tb/tb_chess_clock_timer.sv
// Directed bench for chess_clock_timer: three instances (CLOCK_FREQ=4) share
// reset/start/pause; each has its own turn_end. Times are compared as
// minutes*100 + seconds (e.g. 9959 = 99:59).
module tb_chess_clock_timer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic te_a = 1'b0, te_b = 1'b0, te_c = 1'b0;

  logic       act_a, run_a, act_b, run_b, act_c, run_c;
  logic [1:0] to_a, to_b, to_c;
  logic [6:0] wm_a, bm_a, wm_b, bm_b, wm_c, bm_c;
  logic [2:0] wt_a, bt_a, wt_b, bt_b, wt_c, bt_c;
  logic [3:0] wu_a, bu_a, wu_b, bu_b, wu_c, bu_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  chess_clock_timer #(.CLOCK_FREQ(4), .MINUTES(0), .SECONDS(12), .INCREMENT(0)) dut_a (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .turn_end(te_a),
    .active(act_a), .running(run_a), .timeout(to_a),
    .w_min(wm_a), .w_sec_tens(wt_a), .w_sec_units(wu_a),
    .b_min(bm_a), .b_sec_tens(bt_a), .b_sec_units(bu_a));

  chess_clock_timer #(.CLOCK_FREQ(4), .MINUTES(1), .SECONDS(0), .INCREMENT(5)) dut_b (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .turn_end(te_b),
    .active(act_b), .running(run_b), .timeout(to_b),
    .w_min(wm_b), .w_sec_tens(wt_b), .w_sec_units(wu_b),
    .b_min(bm_b), .b_sec_tens(bt_b), .b_sec_units(bu_b));

  chess_clock_timer #(.CLOCK_FREQ(4), .MINUTES(99), .SECONDS(59), .INCREMENT(5)) dut_c (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .turn_end(te_c),
    .active(act_c), .running(run_c), .timeout(to_c),
    .w_min(wm_c), .w_sec_tens(wt_c), .w_sec_units(wu_c),
    .b_min(bm_c), .b_sec_tens(bt_c), .b_sec_units(bu_c));

  function automatic int tv(input logic [6:0] m, input logic [2:0] t, input logic [3:0] u);
    return int'(m) * 100 + int'(t) * 10 + int'(u);
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are read there too.
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " A.w"}, tv(wm_a, wt_a, wu_a), 12);
    check({tag, " A.b"}, tv(bm_a, bt_a, bu_a), 12);
    check({tag, " B.w"}, tv(wm_b, wt_b, wu_b), 100);
    check({tag, " B.b"}, tv(bm_b, bt_b, bu_b), 100);
    check({tag, " C.w"}, tv(wm_c, wt_c, wu_c), 9959);
    check({tag, " C.b"}, tv(bm_c, bt_c, bu_c), 9959);
    check({tag, " act"}, {act_a, act_b, act_c}, 0);
    check({tag, " run"}, {run_a, run_b, run_c}, 0);
    check({tag, " to"},  {to_a, to_b, to_c}, 0);
  endtask

  initial begin
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check_reset("rst");

    start = 1'b1; cyc(1); start = 1'b0;                   // E0
    check("start run", {run_a, run_b, run_c}, 3'b111);
    check("start act", {act_a, act_b, act_c}, 0);

    cyc(4);                                               // E4: first tick
    check("E4 A.w", tv(wm_a, wt_a, wu_a), 11);
    check("E4 A.b", tv(bm_a, bt_a, bu_a), 12);
    check("E4 B.w", tv(wm_b, wt_b, wu_b), 59);
    check("E4 C.w", tv(wm_c, wt_c, wu_c), 9958);

    te_c = 1'b1; cyc(1); te_c = 1'b0;                     // E5
    check("E5 C.w sat", tv(wm_c, wt_c, wu_c), 9959);
    check("E5 C.act", act_c, 1);

    cyc(3);                                               // E8
    check("E8 A.w", tv(wm_a, wt_a, wu_a), 10);
    check("E8 B.w", tv(wm_b, wt_b, wu_b), 58);
    cyc(1);                                               // E9
    check("E9 C.b", tv(bm_c, bt_c, bu_c), 9958);
    check("E9 C.w", tv(wm_c, wt_c, wu_c), 9959);

    cyc(3);                                               // E12
    check("E12 A.w", tv(wm_a, wt_a, wu_a), 9);
    check("E12 B.w", tv(wm_b, wt_b, wu_b), 57);

    te_b = 1'b1; cyc(1); te_b = 1'b0;                     // E13
    check("E13 B.w inc", tv(wm_b, wt_b, wu_b), 102);
    check("E13 B.act", act_b, 1);
    check("E13 C.b", tv(bm_c, bt_c, bu_c), 9957);

    cyc(2);
    te_a = 1'b1; cyc(1); te_a = 1'b0;                     // E16: A tick cycle
    check("E16 A.w no dec", tv(wm_a, wt_a, wu_a), 9);
    check("E16 A.act", act_a, 1);

    te_b = 1'b1; cyc(1); te_b = 1'b0;                     // E17: B tick cycle
    check("E17 B.b no dec", tv(bm_b, bt_b, bu_b), 105);
    check("E17 B.w", tv(wm_b, wt_b, wu_b), 102);
    check("E17 B.act", act_b, 0);
    check("E17 C.b", tv(bm_c, bt_c, bu_c), 9956);

    start = 1'b1; pause = 1'b1; te_c = 1'b1;
    cyc(1); te_c = 1'b0;                                  // E18
    check("E18 pause wins", {run_a, run_b, run_c}, 0);
    check("E18 C.b te+pause", tv(bm_c, bt_c, bu_c), 9959);
    check("E18 C.act", act_c, 0);

    cyc(1);
    te_a = 1'b1; cyc(1); te_a = 1'b0;                     // E20
    check("paused te ignored", act_a, 1);
    cyc(7);                                               // E27
    check("paused A.b hold", tv(bm_a, bt_a, bu_a), 12);
    check("paused A.w hold", tv(wm_a, wt_a, wu_a), 9);

    pause = 1'b0; cyc(1); start = 1'b0;                   // E28
    check("resume run", {run_a, run_b, run_c}, 3'b111);
    cyc(1);                                               // E29
    check("E29 A.b", tv(bm_a, bt_a, bu_a), 12);
    cyc(1);                                               // E30
    check("E30 A.b", tv(bm_a, bt_a, bu_a), 11);
    check("E30 B.w", tv(wm_b, wt_b, wu_b), 102);

    te_a = 1'b1; cyc(1); te_a = 1'b0;                     // E31
    check("E31 B.w", tv(wm_b, wt_b, wu_b), 101);
    check("E31 A.act", act_a, 0);
    check("E31 C.w", tv(wm_c, wt_c, wu_c), 9959);
    cyc(1);                                               // E32
    check("E32 C.w", tv(wm_c, wt_c, wu_c), 9958);

    cyc(34);                                              // E66
    check("E66 A.w", tv(wm_a, wt_a, wu_a), 1);
    check("E66 A.run", run_a, 1);
    cyc(1);                                               // E67
    check("E67 A.w", tv(wm_a, wt_a, wu_a), 0);
    check("E67 A.to", to_a, 2'b01);
    check("E67 A.run", run_a, 0);
    check("E67 A.b", tv(bm_a, bt_a, bu_a), 11);

    start = 1'b1; te_a = 1'b1; cyc(2); start = 1'b0; te_a = 1'b0;
    check("to hold w", tv(wm_a, wt_a, wu_a), 0);
    check("to hold to", to_a, 2'b01);
    check("to hold run", run_a, 0);
    check("to hold act", act_a, 0);
    check("B,C no to", {to_b, to_c}, 0);

    reset = 1'b1; cyc(1); reset = 1'b0;
    check_reset("rst2");

    start = 1'b1; cyc(1); start = 1'b0;
    cyc(3);
    check("post-rst no early tick", tv(wm_a, wt_a, wu_a), 12);
    cyc(1);
    check("post-rst tick", tv(wm_a, wt_a, wu_a), 11);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/chess_clock_timer.md
CHESS_CLOCK_TIMER -- requirements
Module: chess_clock_timer

Interface
REQ-001 The block SHALL take the following parameters, one per line (name, default, meaning):
- CLOCK_FREQ, 50000000, clock cycles per one-second tick; legal range 2 or more.
- MINUTES, 5, initial minutes per player; legal range 0..99.
- SECONDS, 0, initial seconds per player; legal range 0..59; MINUTES*60+SECONDS SHALL be greater than 0.
- INCREMENT, 0, Fischer increment in seconds added on turn end; legal range 0..59.

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clock, in, 1, single system clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, level-sampled request to begin or resume counting.
- pause, in, 1, level-sampled request to halt counting.
- turn_end, in, 1, single-cycle pulse ending the active player's move.
- active, out, 1, side to move: 0 = white, 1 = black.
- running, out, 1, high in state RUN only.
- timeout, out, 2, bit0 = white flag fallen, bit1 = black flag fallen.
- w_min, out, 7, white minutes in binary, 0..99.
- w_sec_tens, out, 3, white seconds tens digit, 0..5.
- w_sec_units, out, 4, white seconds units digit, 0..9.
- b_min, out, 7, black minutes in binary, 0..99.
- b_sec_tens, out, 3, black seconds tens digit, 0..5.
- b_sec_units, out, 4, black seconds units digit, 0..9.

Function
REQ-003 The block SHALL implement the states IDLE, RUN, PAUSED and TIMEOUT.
REQ-004 In IDLE, start SHALL move the block to RUN with active = 0 on the next edge.
REQ-005 In RUN, pause SHALL move the block to PAUSED; if start and pause are both high, pause SHALL win.
REQ-006 In PAUSED, start with pause low SHALL return the block to RUN with active unchanged.
REQ-007 The prescaler SHALL count 0..CLOCK_FREQ-1 only in RUN, hold its value in PAUSED, and be cleared in IDLE, on reset, and on an accepted turn_end.
REQ-008 A tick SHALL occur on the cycle the prescaler equals CLOCK_FREQ-1 in RUN; the prescaler SHALL then wrap to 0.
REQ-009 Each tick SHALL decrement only the active player's time by one second, with BCD borrow:
- units 0 -> 9 with tens decremented;
- tens:units 0:0 -> 5:9 with minutes decremented.
REQ-010 If a tick makes the active player's time 0:00, the block SHALL set that player's timeout bit and enter TIMEOUT on the same edge.
REQ-011 An accepted turn_end SHALL do all of the following on one edge:
- add INCREMENT seconds to the player who just moved, with BCD carry into minutes;
- saturate that player's time at 99:59;
- toggle active.
REQ-012 turn_end SHALL be accepted only in RUN and SHALL be ignored in IDLE, PAUSED and TIMEOUT.
REQ-013 If a tick and an accepted turn_end coincide, the turn_end SHALL take priority and the tick SHALL be discarded; no decrement and no timeout occur on that edge.
REQ-014 If turn_end and pause coincide in RUN, the block SHALL perform the turn_end per REQ-011 and enter PAUSED.
REQ-015 TIMEOUT SHALL be terminal until reset; start, pause and turn_end SHALL be ignored and all outputs SHALL hold.
REQ-016 The inactive player's time SHALL never change except by the increment of REQ-011.
REQ-017 All outputs SHALL be registered; time outputs SHALL reflect a tick or increment on the edge that applies it (zero added latency).

Reset
REQ-018 On a clock edge with reset high, the following SHALL take effect regardless of state or other inputs:
- state = IDLE, prescaler = 0;
- active = 0, running = 0, timeout = 2'b00;
- both players' minutes = MINUTES, tens = SECONDS/10, units = SECONDS%10.
REQ-019 Reset asserted mid-RUN or in TIMEOUT SHALL fully restore the REQ-018 values on the next edge, with no partial tick applied.

Verification
REQ-020 With CLOCK_FREQ=4, MINUTES=0, SECONDS=12: reset, then start -> white reads 0:11 after 4 cycles and 0:10 after 8 cycles; black holds 0:12.
REQ-021 With MINUTES=1, SECONDS=0: one tick -> white reads 0:59; on a second bench with SECONDS=10, a tick yields 0:09.
REQ-022 With INCREMENT=5, white at 0:57: turn_end in RUN -> white reads 1:02, active = 1, prescaler cleared; white at 99:58 plus turn_end -> 99:59.
REQ-023 With white at 0:01: tick -> white 0:00, timeout = 2'b01, running = 0; subsequent start and turn_end are ignored.
REQ-024 turn_end on the tick cycle -> no decrement, increment applied, active toggled; pause for 10 cycles then start -> the remaining prescaler count resumes with no extra or lost cycles.
REQ-025 Reset asserted during RUN with both clocks partially consumed -> next edge shows IDLE values per REQ-018.
